// File: rtl/gpu_fill_ctrl.sv
// AXI-lite fill engine: writes one constant value to a run of GPU RAM words, one write outstanding at a time.
// Optional build macro GPU_FILL_STRIDE_EN adds a per-fill address stride input (default stride is 1).
module gpu_fill_ctrl #(
    parameter int ADDR_WIDTH  = 22,
    parameter int DATA_WIDTH  = 32,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic [COUNT_WIDTH-1:0] count,
    input  logic [DATA_WIDTH-1:0]  fill_data,
`ifdef GPU_FILL_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0]  fill_stride,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_WIDTH-1:0]  m_awaddr,
    output logic [2:0]             m_awprot,
    output logic                   m_awvalid,
    input  logic                   m_awready,
    output logic [DATA_WIDTH-1:0]  m_wdata,
    output logic                   m_wvalid,
    input  logic                   m_wready,
    input  logic [1:0]             m_bresp,
    input  logic                   m_bvalid,
    output logic                   m_bready
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, FINISH} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [ADDR_WIDTH-1:0]  step;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [COUNT_WIDTH-1:0] remaining_q;
    logic                   aw_done_q;
    logic                   w_done_q;
    logic                   err_q;
    logic                   aw_fire;
    logic                   w_fire;
    logic                   b_fire;
    logic                   aw_complete;
    logic                   w_complete;
    logic                   last_word;

`ifdef GPU_FILL_STRIDE_EN
    logic [ADDR_WIDTH-1:0]  stride_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q <= '0;
        end else if (state == IDLE && start) begin
            stride_q <= fill_stride;
        end
    end

    assign step = stride_q;
`else
    assign step = ADDR_WIDTH'(1);
`endif

    // Handshakes are decoded from state directly so the valid outputs never feed back into them.
    assign aw_fire     = (state == ISSUE) && !aw_done_q && m_awready;
    assign w_fire      = (state == ISSUE) && !w_done_q && m_wready;
    assign b_fire      = (state == RESP) && m_bvalid;
    assign aw_complete = aw_done_q || aw_fire;
    assign w_complete  = w_done_q || w_fire;
    assign last_word   = (remaining_q == COUNT_WIDTH'(1));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_next = state;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (count == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                m_awvalid = !aw_done_q;
                m_wvalid  = !w_done_q;
                if (aw_complete && w_complete) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    state_next = last_word ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            remaining_q <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q      <= start_addr;
                        data_q      <= fill_data;
                        remaining_q <= count;
                        err_q       <= 1'b0;
                        aw_done_q   <= 1'b0;
                        w_done_q    <= 1'b0;
                    end
                end
                ISSUE: begin
                    // Per-channel completion flags re-arm as soon as both channels are through.
                    if (aw_complete && w_complete) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        if (aw_fire) aw_done_q <= 1'b1;
                        if (w_fire)  w_done_q  <= 1'b1;
                    end
                end
                RESP: begin
                    if (b_fire) begin
                        if (m_bresp != 2'b00) err_q <= 1'b1;
                        remaining_q <= remaining_q - COUNT_WIDTH'(1);
                        addr_q      <= addr_q + step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == FINISH);
    assign err      = err_q;
    assign m_awaddr = addr_q;
    assign m_wdata  = data_q;
    assign m_awprot = 3'b000;

endmodule

// File: tb/tb_gpu_fill_ctrl.sv
// Self-checking bench for gpu_fill_ctrl: a reactive AXI-lite slave logs writes, and each fill is compared
// with an arithmetic reference of the expected word list, error flag and zero-wait latency.
module tb_gpu_fill_ctrl;
    localparam int AW = 22;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [CW-1:0] count = '0;
    logic [DW-1:0] fill_data = '0;
    logic          busy, done, err;
    logic [AW-1:0] m_awaddr;
    logic [2:0]    m_awprot;
    logic          m_awvalid, m_wvalid, m_bready;
    logic          m_awready = 1'b0;
    logic          m_wready = 1'b0;
    logic [DW-1:0] m_wdata;
    logic [1:0]    m_bresp = 2'b00;
    logic          m_bvalid = 1'b0;

    gpu_fill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .fill_data  (fill_data),
`ifdef GPU_FILL_STRIDE_EN
        .fill_stride(AW'(1)),
`endif
        .busy       (busy),
        .done       (done),
        .err        (err),
        .m_awaddr   (m_awaddr),
        .m_awprot   (m_awprot),
        .m_awvalid  (m_awvalid),
        .m_awready  (m_awready),
        .m_wdata    (m_wdata),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .m_bresp    (m_bresp),
        .m_bvalid   (m_bvalid),
        .m_bready   (m_bready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave configuration and logs
    bit            rand_mode = 1'b0;
    int            aw_stall = 0;
    int            w_stall = 0;
    int            err_word = -1;
    logic [AW-1:0] aw_q[$];
    logic [DW-1:0] w_q[$];
    logic [1:0]    resp_q[$];
    logic [AW-1:0] wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];
    logic [1:0]    bresp_log[$];
    int            widx = 0;
    int            acc_cnt = 0;
    int            aw_hs = 0;
    int            w_hs = 0;
    bit            awvalid_seen = 1'b0;
    bit            pend_aw = 1'b0;
    bit            pend_w = 1'b0;
    logic [AW-1:0] last_awaddr = '0;
    logic [DW-1:0] last_wdata = '0;

    task automatic clear_logs();
        wr_addr_log.delete();
        wr_data_log.delete();
        bresp_log.delete();
        widx = 0;
        acc_cnt = 0;
        aw_hs = 0;
        w_hs = 0;
        awvalid_seen = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_awready = 1'b0;
            m_wready  = 1'b0;
            m_bvalid  = 1'b0;
            m_bresp   = 2'b00;
            aw_q.delete();
            w_q.delete();
            resp_q.delete();
            pend_aw = 1'b0;
            pend_w  = 1'b0;
        end else begin
            if (rand_mode) begin
                m_awready = ($urandom_range(0, 2) != 0);
                m_wready  = ($urandom_range(0, 2) != 0);
                m_bvalid  = (resp_q.size() != 0) && ($urandom_range(0, 2) != 0);
            end else begin
                m_awready = (aw_stall == 0);
                m_wready  = (w_stall == 0);
                m_bvalid  = (resp_q.size() != 0);
            end
            m_bresp = (resp_q.size() != 0) ? resp_q[0] : 2'b00;
            #1;
            if (pend_aw) begin
                check("aw_valid_hold", m_awvalid, 1);
                check("aw_addr_stable", m_awaddr, last_awaddr);
            end
            if (pend_w) begin
                check("w_valid_hold", m_wvalid, 1);
                check("w_data_stable", m_wdata, last_wdata);
            end
            if (m_bready) begin
                check("aw_low_in_resp", m_awvalid, 0);
                check("w_low_in_resp", m_wvalid, 0);
            end
            if (m_awvalid) begin
                check("awprot", m_awprot, 3'b000);
                awvalid_seen = 1'b1;
                if (!m_awready && aw_stall > 0) aw_stall--;
            end
            if (m_wvalid && !m_wready && w_stall > 0) w_stall--;
            pend_aw = m_awvalid && !m_awready;
            pend_w  = m_wvalid && !m_wready;
            last_awaddr = m_awaddr;
            last_wdata  = m_wdata;
            if (m_bvalid && m_bready) begin
                void'(resp_q.pop_front());
                acc_cnt++;
            end
            if (m_awvalid && m_awready) begin
                aw_q.push_back(m_awaddr);
                aw_hs++;
            end
            if (m_wvalid && m_wready) begin
                w_q.push_back(m_wdata);
                w_hs++;
            end
            while (aw_q.size() != 0 && w_q.size() != 0) begin
                logic [1:0] r;
                if (rand_mode) r = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                else           r = (widx == err_word) ? 2'b10 : 2'b00;
                wr_addr_log.push_back(aw_q.pop_front());
                wr_data_log.push_back(w_q.pop_front());
                bresp_log.push_back(r);
                resp_q.push_back(r);
                widx++;
            end
        end
    end

    // Reference: word i lands at (base + i) modulo 2**AW.
    function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int i);
        longint unsigned full;
        full = 64'(base) + 64'(i);
        return AW'(full % (64'd1 << AW));
    endfunction

    task automatic run_fill(input logic [AW-1:0] a, input int n, input logic [DW-1:0] d, input int exp_lat);
        int cyc = 0;
        int busy_cyc = 0;
        bit seen = 1'b0;
        bit exp_err = 1'b0;
        clear_logs();
        @(negedge clk);
        #2;
        start = 1'b1;
        start_addr = a;
        count = CW'(n);
        fill_data = d;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            #2;
            cyc++;
            if (cyc == 1) check("err_cleared_on_start", err, 0);
            if (busy) busy_cyc++;
            if (done) seen = 1'b1;
            start_addr = AW'($urandom);
            count = CW'($urandom);
            fill_data = $urandom;
            start = rand_mode && !done && ($urandom_range(0, 4) == 0);
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        if (exp_lat > 0) check("latency", cyc, exp_lat);
        if (n == 0) begin
            check("zero_busy_cycles", busy_cyc, 1);
            check("zero_no_awvalid", awvalid_seen, 0);
        end
        check("write_count", wr_addr_log.size(), n);
        check("aw_handshakes", aw_hs, n);
        check("w_handshakes", w_hs, n);
        for (int i = 0; i < n && i < wr_addr_log.size(); i++) begin
            check("write_addr", wr_addr_log[i], model_addr(a, i));
            check("write_data", wr_data_log[i], d);
            if (bresp_log[i] != 2'b00) exp_err = 1'b1;
        end
        check("err_at_done", err, exp_err);
        @(negedge clk);
        #2;
        check("err_hold", err, exp_err);
        check("idle_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    task automatic reset_mid_fill();
        int k = 0;
        bit hit = 1'b0;
        clear_logs();
        @(negedge clk);
        #2;
        start = 1'b1;
        start_addr = AW'(22'h100);
        count = CW'(4);
        fill_data = 32'h5A5A_0001;
        while (!hit && k < 200) begin
            @(negedge clk);
            #2;
            start = 1'b0;
            k++;
            if (m_bready && acc_cnt == 2) hit = 1'b1;
        end
        check("resp_word2_reached", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_bready", m_bready, 0);
        check("rst_awaddr", m_awaddr, 0);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_awvalid", m_awvalid, 0);
        check("reset_wvalid", m_wvalid, 0);
        check("reset_bready", m_bready, 0);
        check("reset_awaddr", m_awaddr, 0);
        check("reset_wdata", m_wdata, 0);
        check("reset_awprot", m_awprot, 0);
        rst = 1'b0;

        run_fill(AW'(22'h10), 3, 32'hABC, 7);
        run_fill(AW'(22'h20), 0, 32'h1234, 1);
        aw_stall = 3;
        w_stall = 5;
        run_fill(AW'(22'h40), 1, 32'hCAFE_F00D, 8);
        run_fill(AW'(22'h3F_FFFF), 2, 32'h0BAD_BEEF, 5);
        err_word = 1;
        run_fill(AW'(22'h80), 3, 32'h1111_2222, 7);
        err_word = -1;
        run_fill(AW'(22'h90), 2, 32'h3333_4444, 5);
        reset_mid_fill();
        run_fill(AW'(22'h200), 1, 32'h7777_8888, 3);

        rand_mode = 1'b1;
        for (int t = 0; t < 30; t++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 3) == 0) a = AW'(22'h3F_FFFF) - AW'($urandom_range(0, 3));
            else                           a = AW'($urandom);
            run_fill(a, $urandom_range(0, 5), $urandom, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_fill_ctrl.md
GPU_FILL_CTRL -- requirements
Module: gpu_fill_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 22, AXI-lite write address width (word-indexed GPU RAM address).
REQ-002 Parameter DATA_WIDTH, default 32, write data width.
REQ-003 Parameter COUNT_WIDTH, default 16, width of the transfer word count.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to begin a fill; sampled only in IDLE.
REQ-007 start_addr  input  ADDR_WIDTH  first word address.
REQ-008 count  input  COUNT_WIDTH  number of words to write.
REQ-009 fill_data  input  DATA_WIDTH  value written to every word.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle pulse when a fill completes.
REQ-012 err  output  1  sticky flag: some response in the current fill had bresp != 0.
REQ-013 m_awaddr/m_awprot/m_awvalid/m_awready  out/out/out/in  ADDR_WIDTH/3/1/1  AXI-lite write address channel (master).
REQ-014 m_wdata/m_wvalid/m_wready  out/out/in  DATA_WIDTH/1/1  AXI-lite write data channel (master).
REQ-015 m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI-lite write response channel (master).

Function
REQ-016 States SHALL be IDLE, ISSUE, RESP, FINISH.
REQ-017 IDLE, start=1: latch start_addr, count, fill_data; clear err; count!=0 -> ISSUE, count==0 -> FINISH with no bus traffic.
REQ-018 IDLE, start=0: remain in IDLE; m_awvalid=m_wvalid=m_bready=0.
REQ-019 start while busy SHALL be ignored; latched operands SHALL not change.
REQ-020 ISSUE entry: m_awvalid and m_wvalid SHALL both assert in the same cycle, with m_awaddr = current address, m_wdata = latched data, m_awprot = 3'b000.
REQ-021 Each valid SHALL stay high, payload stable, until its own ready is seen high; the two channels complete independently, in any order or the same cycle.
REQ-022 When both channels have completed, the FSM SHALL move to RESP; m_awvalid and m_wvalid SHALL be low in RESP.
REQ-023 m_bready SHALL be high only in RESP; a response is accepted on m_bvalid && m_bready.
REQ-024 On response acceptance: if m_bresp != 0, set err; decrement remaining count; advance address by stride.
REQ-025 After response acceptance: remaining == 0 -> FINISH, else -> ISSUE for the next word, with no idle cycle.
REQ-026 FINISH SHALL last one cycle, assert done=1, then go to IDLE; busy SHALL be high in FINISH.
REQ-027 Address arithmetic SHALL be modulo 2**ADDR_WIDTH; wrap past the top SHALL continue from 0 silently.
REQ-028 Minimum per-word cost: 2 cycles (ISSUE, RESP) with zero-wait slave; a fill of N words takes 2N+1 cycles from start to done pulse inclusive of FINISH.
REQ-029 err SHALL hold its value after done until the next accepted start.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE regardless of state, including mid-transaction.
REQ-031 Reset values: busy=0, done=0, err=0, m_awvalid=0, m_wvalid=0, m_bready=0, m_awaddr=0, m_wdata=0, m_awprot=0.
REQ-032 A transaction interrupted by reset SHALL be abandoned; no retry on reset release.

Configuration
REQ-033 Macro GPU_FILL_STRIDE_EN defined: add input fill_stride (ADDR_WIDTH, latched on start); address advances by fill_stride per word (stride 0 SHALL rewrite the same address).
REQ-034 Macro GPU_FILL_STRIDE_EN undefined: no fill_stride port; stride fixed to 1.

Verification
REQ-035 start, start_addr=0x10, count=3, fill_data=0xABC, zero-wait slave -> writes 0x10/0x11/0x12 with 0xABC, done pulse on cycle 7 after start, err=0.
REQ-036 count=0 -> no m_awvalid ever asserted; done pulses on the cycle after start; busy high for exactly 1 cycle.
REQ-037 Slave holds m_awready low 3 cycles, m_wready low 5 cycles on word 0 -> m_awvalid drops after the AW handshake, m_wvalid stays high until the W handshake; payloads stable; single write.
REQ-038 start_addr=2**22-1, count=2 -> addresses 0x3FFFFF then 0x000000.
REQ-039 Slave returns bresp=2 on word 1 of 3 -> all 3 words still written, err=1 after done, err cleared by the next start.
REQ-040 rst asserted in RESP of word 2 of 4 -> next cycle busy=0, all valids/bready low; a new start=1 count=1 completes normally.
